// File: rtl/scan_multi_chain_if.sv
// FIFO-side bundle for the multi-chain scan controller:
// restore words come in on the pop side, captured words leave on the push side.
interface scan_multi_chain_if #(
  parameter int DATA_W = 32
);
  logic              rd_en;
  logic [DATA_W-1:0] data_out;
  logic              empty;
  logic              wr_en;
  logic [DATA_W-1:0] data_in;
  logic              almost_full;

  modport master (
    output rd_en, wr_en, data_in,
    input  data_out, empty, almost_full
  );

  modport slave (
    input  rd_en, wr_en, data_in,
    output data_out, empty, almost_full
  );
endinterface

// File: rtl/scan_multi_chain.sv
// Multi-chain scan controller: parallel shift of NUM_CHAINS chains, MSB first.
// Optional scan-clock stretching is enabled with SCAN_CLK_DIV_EN.
module scan_multi_chain #(
  parameter int DATA_W     = 32,
  parameter int NUM_CHAINS = 4,
  parameter int LEN_W      = 16
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  start,
  input  logic [LEN_W-1:0]      length,
`ifdef SCAN_CLK_DIV_EN
  input  logic [7:0]            clk_div,
`endif
  output logic [NUM_CHAINS-1:0] scan_input,
  input  logic [NUM_CHAINS-1:0] scan_output,
  output logic                  scan_ck_enable,
  output logic                  scan_enable,
  output logic                  busy,
  output logic                  done,
  scan_multi_chain_if.master    fifo
);

  localparam int BI  = $clog2(DATA_W);
  localparam int B_W = BI + 1;
  localparam int WI  = (NUM_CHAINS > 1) ? $clog2(NUM_CHAINS) : 1;
  localparam int W_W = WI + 1;

  typedef enum logic [2:0] {
    IDLE, POP, WAIT_POP, SHIFT_LOW, SHIFT_HIGH, PUSH, DONE
  } state_t;

  state_t state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [B_W-1:0]   b_q, b_d;
  logic [W_W-1:0]   w_q, w_d;
  logic [NUM_CHAINS-1:0][DATA_W-1:0] inbuf_q, inbuf_d;
  logic [NUM_CHAINS-1:0][DATA_W-1:0] capbuf_q, capbuf_d;
  logic [WI-1:0] widx;
  logic [BI-1:0] bpos;
  logic          phase_last;
  logic          shifting;

  assign widx     = w_q[WI-1:0];
  // DATA_W is a power of two, so DATA_W-1-b is the bitwise inverse
  assign bpos     = ~b_q[BI-1:0];
  assign shifting = (state_q == SHIFT_LOW) || (state_q == SHIFT_HIGH);

`ifdef SCAN_CLK_DIV_EN
  logic [7:0] div_q, div_d;
  logic [7:0] cnt_q, cnt_d;
  assign phase_last = (cnt_q == div_q);
`else
  assign phase_last = 1'b1;
`endif

  // Outputs decoded from state; only rd_en/wr_en see FIFO flags
  always_comb begin
    scan_input = '0;
    if (shifting) begin
      for (int c = 0; c < NUM_CHAINS; c++) begin
        scan_input[c] = inbuf_q[c][bpos];
      end
    end
  end

  assign scan_ck_enable = (state_q == SHIFT_HIGH);
  assign scan_enable    = (state_q != IDLE) && (state_q != DONE);
  assign busy           = (state_q != IDLE);
  assign done           = (state_q == DONE);
  assign fifo.rd_en     = (state_q == POP) && !fifo.empty;
  assign fifo.wr_en     = (state_q == PUSH) && !fifo.almost_full;
  assign fifo.data_in   = (state_q == PUSH) ? capbuf_q[widx] : '0;

  // Next-state, counter and buffer update
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    b_d      = b_q;
    w_d      = w_q;
    inbuf_d  = inbuf_q;
    capbuf_d = capbuf_q;
`ifdef SCAN_CLK_DIV_EN
    div_d    = div_q;
    cnt_d    = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
`ifdef SCAN_CLK_DIV_EN
          div_d = clk_div;
          cnt_d = '0;
`endif
          if (length == '0) begin
            state_d = DONE;
          end else begin
            rem_d   = length;
            w_d     = '0;
            state_d = POP;
          end
        end
      end
      POP: begin
        if (!fifo.empty) state_d = WAIT_POP;
      end
      WAIT_POP: begin
        inbuf_d[widx]  = fifo.data_out;
        capbuf_d[widx] = '0;
        if (w_q == W_W'(NUM_CHAINS - 1)) begin
          w_d     = '0;
          b_d     = '0;
          state_d = SHIFT_LOW;
        end else begin
          w_d     = w_q + W_W'(1);
          state_d = POP;
        end
      end
      SHIFT_LOW: begin
        if (phase_last) begin
          for (int c = 0; c < NUM_CHAINS; c++) begin
            capbuf_d[c][bpos] = scan_output[c];
          end
          state_d = SHIFT_HIGH;
        end
      end
      SHIFT_HIGH: begin
        if (phase_last) begin
          rem_d = rem_q - LEN_W'(1);
          b_d   = b_q + B_W'(1);
          if ((rem_q == LEN_W'(1)) || (b_q == B_W'(DATA_W - 1)))
            state_d = PUSH;
          else
            state_d = SHIFT_LOW;
        end
      end
      PUSH: begin
        if (!fifo.almost_full) begin
          if (w_q == W_W'(NUM_CHAINS - 1)) begin
            w_d     = '0;
            state_d = (rem_q != '0) ? POP : DONE;
          end else begin
            w_d = w_q + W_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
`ifdef SCAN_CLK_DIV_EN
    if (shifting) cnt_d = phase_last ? 8'd0 : cnt_q + 8'd1;
`endif
  end

  // State and datapath registers, synchronous reset
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      b_q      <= '0;
      w_q      <= '0;
      inbuf_q  <= '0;
      capbuf_q <= '0;
`ifdef SCAN_CLK_DIV_EN
      div_q    <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      b_q      <= b_d;
      w_q      <= w_d;
      inbuf_q  <= inbuf_d;
      capbuf_q <= capbuf_d;
`ifdef SCAN_CLK_DIV_EN
      div_q    <= div_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

endmodule

// File: doc/scan_multi_chain.md
# scan_multi_chain

Parametrised multi-chain scan controller for HardSnap state capture and restore. It shifts `NUM_CHAINS` scan chains in parallel, one bit per chain per scan clock. Restore data is popped from the input FIFO (one `DATA_W` word per chain per chunk) and captured data is pushed to the output FIFO in the same layout. Successor of the single-chain controller: adds width, chain count, partial-chunk flush, a `done` pulse, `busy`, and optional scan-clock stretching.

## Interface
- `DATA_W`, 32, FIFO word width and chunk size in bits per chain (power of 2, 8..64)
- `NUM_CHAINS`, 4, parallel scan chains (1..16)
- `LEN_W`, 16, width of `length`
- `aclk`  in  1  clock
- `areset`  in  1  reset: one clock; reset is synchronous and active-high
- `start`  in  1  one-cycle pulse, sampled only in IDLE
- `length`  in  LEN_W  bits to shift per chain, sampled with `start`
- `scan_input`  out  NUM_CHAINS  serial data into each chain
- `scan_output`  in  NUM_CHAINS  serial data from each chain
- `scan_ck_enable`  out  1  scan clock gate
- `scan_enable`  out  1  chains in shift mode
- `rd_en`  out  1  input-FIFO pop
- `data_out`  in  DATA_W  input-FIFO data, valid the cycle after `rd_en`
- `empty`  in  1  input FIFO empty
- `wr_en`  out  1  output-FIFO push
- `data_in`  out  DATA_W  output-FIFO data
- `almost_full`  in  1  output FIFO cannot accept a word
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse when an operation completes

## Operation
- States: IDLE, POP, WAIT_POP, SHIFT_LOW, SHIFT_HIGH, PUSH, DONE.
- IDLE:
  - `start`=1 with `length`=0 goes to DONE.
  - `start`=1 with nonzero `length` latches `remaining`=`length`, sets word index `w`=0, and goes to POP.
- POP: `rd_en`=1 when `empty`=0, then go to WAIT_POP. While `empty`=1, stay in POP with `rd_en`=0.
- WAIT_POP:
  - Latch `data_out` into input buffer `w` and clear capture buffer `w`.
  - If `w`=NUM_CHAINS-1, set `w`=0, bit counter `b`=0, and go to SHIFT_LOW. Otherwise increment `w` and return to POP.
- Bit order is MSB first. `scan_input[c]` = `inbuf[c][DATA_W-1-b]` in all shift states.
- SHIFT_LOW: `scan_output[c]` is written into `capbuf[c][DATA_W-1-b]`, then go to SHIFT_HIGH.
- SHIFT_HIGH: `scan_ck_enable`=1, decrement `remaining`, increment `b`.
  - If `remaining` reaches 0 or `b` reaches DATA_W, go to PUSH.
  - Otherwise go to SHIFT_LOW.
- PUSH: `data_in` = `capbuf[w]`. Bits not captured in a partial chunk are 0.
  - `wr_en` = !`almost_full`. `w` increments only on cycles where `wr_en`=1.
  - After word NUM_CHAINS-1 is written: if `remaining`>0, go to POP with `w`=0; otherwise go to DONE.
- DONE: `done`=1 for one cycle, then go to IDLE. The DONE state never writes the FIFO.
- `scan_enable`=1 in POP, WAIT_POP, SHIFT_LOW, SHIFT_HIGH and PUSH; 0 in IDLE and DONE.
- `start` is ignored while `busy`=1.
- Reset mid-operation: on the next edge go to IDLE and clear all buffers, counters and outputs. No partial push is issued.
- Counters: `remaining` is LEN_W bits; `b` and `w` are sized by $clog2 with one extra bit so they never wrap.

## Timing
- Reset values: `scan_input`=0, `scan_ck_enable`=0, `scan_enable`=0, `rd_en`=0, `wr_en`=0, `data_in`=0, `busy`=0, `done`=0.
- Control outputs are decoded from state. `rd_en` also gates on `empty`, and `wr_en` also gates on `almost_full`; there are no other combinational input-to-output paths.
- Read latency: `rd_en` in cycle t means `data_out` is sampled at the end of cycle t+1.
- Each bit takes 2 cycles (1 low, 1 high) without stretching.
- Chunk latency with no backpressure: 2·NUM_CHAINS + 2·min(DATA_W, remaining) + NUM_CHAINS cycles.
- Minimum `start`-to-`done` latency for `length`=0: `done` asserts 1 cycle after `start`.

## Configuration
- Macro: `SCAN_CLK_DIV_EN`.
- Defined:
  - Adds input `clk_div` [7:0], sampled with `start`.
  - SHIFT_LOW and SHIFT_HIGH each last `clk_div`+1 cycles.
  - `scan_output` is sampled on the last SHIFT_LOW cycle. `remaining` and `b` update on the last SHIFT_HIGH cycle.
  - `scan_ck_enable` stays high for the whole SHIFT_HIGH phase.
- Undefined: the `clk_div` port is absent and each phase is exactly 1 cycle.

## Test plan
- DATA_W=32, NUM_CHAINS=4, `length`=32, FIFO holds 4 words, loopback `scan_output`=`scan_input`:
  - Expect exactly 4 `rd_en`, 32 `scan_ck_enable` pulses, 4 pushed words equal to the popped words, one `done`.
  - Total time is 8+64+4 cycles plus DONE.
- `length`=40, chains tied to constant 1: expect 8 pushes. Words 0-3 are 0xFFFFFFFF; words 4-7 are 0xFF000000.
- `length`=0: `done` asserts 1 cycle after `start`; there are no `rd_en`, `wr_en` or `scan_ck_enable` pulses.
- `empty`=1 for 10 cycles during the second POP: `rd_en` stays low and the FSM holds in POP. Operation resumes with no lost bits.
  - `almost_full`=1 for 5 cycles mid-PUSH: `wr_en` stays low and the same word is written once the stall clears.
- `areset` asserted during SHIFT_HIGH: next cycle all outputs are 0 and `busy`=0.
  - A following `start` completes correctly.
  - With `SCAN_CLK_DIV_EN` and `clk_div`=3, each bit takes 8 cycles.
